// File: rtl/spr_wb_pkg.sv
// Shared definitions for the SPR write-back controller: default widths,
// the fixed SPR numbers used by branch-unit updates, and the write entry.
package spr_wb_pkg;

   localparam int SPR_ADDR_W = 10;
   localparam int SPR_DATA_W = 32;

   localparam logic [SPR_ADDR_W-1:0] SPR_LR_ADDR  = 10'd8;
   localparam logic [SPR_ADDR_W-1:0] SPR_CTR_ADDR = 10'd9;

   // One pending register-file write.
   typedef struct packed {
      logic [SPR_ADDR_W-1:0] addr;
      logic [SPR_DATA_W-1:0] data;
   } req_t;

endpackage

// File: rtl/spr_wb_fifo.sv
// Overflow ring buffer for the SPR write-back controller.
// Accepts up to 3 pushes and 2 pops per cycle. Entries are presented in age
// order (index 0 = oldest) with a valid mask, so the parent can pick the
// heads for issue and scan every pending address for hazards.
module spr_wb_fifo
   import spr_wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             push_n,
   input  req_t [2:0]             push_q,
   input  logic [1:0]             pop_n,
   output logic [CW-1:0]          count,
   output req_t [DEPTH-1:0]       age_q,
   output logic [DEPTH-1:0]       age_vld
);

   req_t          mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Pointers wrap naturally (power-of-2 depth); occupancy lives in count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(pop_n);
         wr_ptr <= wr_ptr + PW'(push_n);
         count  <= count - CW'(pop_n) + CW'(push_n);
      end
   end

   // Storage write: push slot i lands at wr_ptr + i.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (2'(i) < push_n) mem[wr_ptr + PW'(i)] <= push_q[i];
      end
   end

   // Age-ordered view of the ring.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         age_q[k]   = mem[rd_ptr + PW'(k)];
         age_vld[k] = CW'(k) < count;
      end
   end

endmodule

// File: rtl/spr_wb_ctrl.sv
// SPR write-back controller: merges FIFO backlog, mtspr, CTR and LR writes
// in program order onto two registered register-file write ports, buffers
// the overflow and reports pending writes to the mfspr query address.
// Optional feature macro: SPR_WB_FWD_EN adds q_data (youngest pending value).
// Struct fields follow the package widths; ADDR_W/DATA_W must match them.
module spr_wb_ctrl
   import spr_wb_pkg::*;
#(
   parameter int                ADDR_W     = SPR_ADDR_W,
   parameter int                DATA_W     = SPR_DATA_W,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] LR_ADDR    = SPR_LR_ADDR,
   parameter logic [ADDR_W-1:0] CTR_ADDR   = SPR_CTR_ADDR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mt_vld,
   input  logic [ADDR_W-1:0] mt_addr,
   input  logic [DATA_W-1:0] mt_data,
   input  logic              ctr_vld,
   input  logic [DATA_W-1:0] ctr_data,
   input  logic              lr_vld,
   input  logic [DATA_W-1:0] lr_data,
   output logic              stall,
   output logic              wr0,
   output logic [ADDR_W-1:0] waddr0,
   output logic [DATA_W-1:0] wd0,
   output logic              wr1,
   output logic [ADDR_W-1:0] waddr1,
   output logic [DATA_W-1:0] wd1,
   input  logic [ADDR_W-1:0] q_addr,
   output logic              q_hit,
`ifdef SPR_WB_FWD_EN
   output logic [DATA_W-1:0] q_data,
`endif
   output logic              ovf_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]         count;
   req_t [FIFO_DEPTH-1:0] age_q;
   logic [FIFO_DEPTH-1:0] age_vld;
   req_t [2:0]            push_q;
   logic [1:0]            push_n;
   logic [1:0]            pop_n;
   req_t                  lst [8];
   logic [2:0]            n;
   logic [2:0]            want;
   logic [CW:0]           room;

   spr_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_n  (push_n),
      .push_q  (push_q),
      .pop_n   (pop_n),
      .count   (count),
      .age_q   (age_q),
      .age_vld (age_vld)
   );

   // Threshold leaves room for the worst-case +1 net growth per cycle.
   assign stall = count >= CW'(FIFO_DEPTH - 1);

   // Rank all valid writes oldest-first; first two issue, the rest are
   // pushed, truncated to the space left after this cycle's pops.
   always_comb begin
      for (int i = 0; i < 8; i++) lst[i] = '0;
      n = '0;
      if (age_vld[0]) begin lst[n] = age_q[0]; n = n + 3'd1; end
      if (age_vld[1]) begin lst[n] = age_q[1]; n = n + 3'd1; end
      if (mt_vld)  begin lst[n] = '{addr: mt_addr,  data: mt_data};  n = n + 3'd1; end
      if (ctr_vld) begin lst[n] = '{addr: CTR_ADDR, data: ctr_data}; n = n + 3'd1; end
      if (lr_vld)  begin lst[n] = '{addr: LR_ADDR,  data: lr_data};  n = n + 3'd1; end
      pop_n  = age_vld[1] ? 2'd2 : (age_vld[0] ? 2'd1 : 2'd0);
      want   = (n > 3'd2) ? n - 3'd2 : 3'd0;
      room   = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + (CW+1)'(pop_n);
      push_n = ((CW+1)'(want) > room) ? room[1:0] : want[1:0];
      for (int i = 0; i < 3; i++) push_q[i] = lst[i + 2];
   end

   // Output stage: rank 1 to port 0, rank 2 to port 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr0    <= 1'b0;
         waddr0 <= '0;
         wd0    <= '0;
         wr1    <= 1'b0;
         waddr1 <= '0;
         wd1    <= '0;
      end else begin
         wr0    <= n > 3'd0;
         waddr0 <= lst[0].addr;
         wd0    <= lst[0].data;
         wr1    <= n > 3'd1;
         waddr1 <= lst[1].addr;
         wd1    <= lst[1].data;
      end
   end

   // Sticky flag: any request offered while stall was asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      ovf_err <= 1'b0;
      else if (stall && (mt_vld || ctr_vld || lr_vld)) ovf_err <= 1'b1;
   end

   // Hazard scan over the output ports and every live FIFO entry.
   always_comb begin
      q_hit = (wr0 && waddr0 == q_addr) || (wr1 && waddr1 == q_addr);
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         if (age_vld[k] && age_q[k].addr == q_addr) q_hit = 1'b1;
      end
   end

`ifdef SPR_WB_FWD_EN
   // Youngest match wins: ports are older than any FIFO entry, so later
   // assignments (port 1, then FIFO oldest to newest) override earlier ones.
   always_comb begin
      q_data = '0;
      if (wr0 && waddr0 == q_addr) q_data = wd0;
      if (wr1 && waddr1 == q_addr) q_data = wd1;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         if (age_vld[k] && age_q[k].addr == q_addr) q_data = age_q[k].data;
      end
   end
`endif

endmodule

// File: tb/tb_spr_wb_ctrl.sv
// Self-checking bench for spr_wb_ctrl: directed scenarios followed by random
// traffic, compared against a program-order queue model of pending writes.
module tb_spr_wb_ctrl;

   localparam int FD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mt_vld = 1'b0, ctr_vld = 1'b0, lr_vld = 1'b0;
   logic [9:0]  mt_addr = '0;
   logic [31:0] mt_data = '0, ctr_data = '0, lr_data = '0;
   logic [9:0]  q_addr = '0;
   logic        stall, wr0, wr1, q_hit, ovf_err;
   logic [9:0]  waddr0, waddr1;
   logic [31:0] wd0, wd1;
`ifdef SPR_WB_FWD_EN
   logic [31:0] q_data;
`endif

   spr_wb_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .mt_vld(mt_vld), .mt_addr(mt_addr), .mt_data(mt_data),
      .ctr_vld(ctr_vld), .ctr_data(ctr_data),
      .lr_vld(lr_vld), .lr_data(lr_data),
      .stall(stall),
      .wr0(wr0), .waddr0(waddr0), .wd0(wd0),
      .wr1(wr1), .waddr1(waddr1), .wd1(wd1),
      .q_addr(q_addr), .q_hit(q_hit),
`ifdef SPR_WB_FWD_EN
      .q_data(q_data),
`endif
      .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t pend[$];   // writes not yet on a port, program order
   ent_t iss[$];    // writes on the ports this cycle
   bit   m_ovf;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic qchk(input logic [9:0] qa);
      logic       h;
      logic [31:0] v;
      h = 1'b0;
      v = '0;
      q_addr = qa;
      #1;
      foreach (iss[i])  if (iss[i].a == qa)  begin h = 1'b1; v = iss[i].d;  end
      foreach (pend[i]) if (pend[i].a == qa) begin h = 1'b1; v = pend[i].d; end
      chk("q_hit", 64'(q_hit), 64'(h));
`ifdef SPR_WB_FWD_EN
      if (h) chk("q_data", 64'(q_data), 64'(v));
`endif
   endtask

   // One clock: offer requests, advance the model, check the new outputs.
   task automatic step(input bit mv, input logic [9:0] ma, input logic [31:0] md,
                       input bit cv, input logic [31:0] cd,
                       input bit lv, input logic [31:0] ld, input logic [9:0] qa);
      ent_t lst[$];
      ent_t e;
      bit   st;
      st = pend.size() >= FD - 1;
      chk("stall", 64'(stall), 64'(st));
      if ((mv || cv || lv) && st) m_ovf = 1'b1;
      mt_vld = mv; mt_addr = ma; mt_data = md;
      ctr_vld = cv; ctr_data = cd;
      lr_vld = lv; lr_data = ld;
      lst = pend;
      if (mv) begin e.a = ma;    e.d = md; lst.push_back(e); end
      if (cv) begin e.a = 10'd9; e.d = cd; lst.push_back(e); end
      if (lv) begin e.a = 10'd8; e.d = ld; lst.push_back(e); end
      iss.delete();
      pend.delete();
      foreach (lst[i]) begin
         if (i < 2) iss.push_back(lst[i]);
         else if (pend.size() < FD) pend.push_back(lst[i]);
      end
      @(posedge clk);
      #1;
      mt_vld = 1'b0; ctr_vld = 1'b0; lr_vld = 1'b0;
      chk("wr0", 64'(wr0), 64'(iss.size() > 0));
      if (iss.size() > 0) begin
         chk("waddr0", 64'(waddr0), 64'(iss[0].a));
         chk("wd0", 64'(wd0), 64'(iss[0].d));
      end
      chk("wr1", 64'(wr1), 64'(iss.size() > 1));
      if (iss.size() > 1) begin
         chk("waddr1", 64'(waddr1), 64'(iss[1].a));
         chk("wd1", 64'(wd1), 64'(iss[1].d));
      end
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      qchk(qa);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, '0, '0, 0, '0, 0, '0, 10'd8);
   endtask

   function automatic logic [9:0] rnd_addr();
      logic [9:0] a;
      case ($urandom_range(0, 4))
         0: a = 10'd8;
         1: a = 10'd9;
         2: a = 10'h100;
         3: a = 10'h101;
         default: a = 10'($urandom);
      endcase
      return a;
   endfunction

   task automatic rnd_step(input bit obey);
      bit mv, cv, lv;
      mv = $urandom_range(0, 1) == 1;
      cv = $urandom_range(0, 2) == 0;
      lv = $urandom_range(0, 2) == 0;
      if (obey && pend.size() >= FD - 1) begin mv = 0; cv = 0; lv = 0; end
      step(mv, rnd_addr(), $urandom, cv, $urandom, lv, $urandom, rnd_addr());
   endtask

   initial begin
      m_ovf = 1'b0;
      #3;
      chk("rst_wr0", 64'(wr0), 64'd0);
      chk("rst_wr1", 64'(wr1), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_q_hit", 64'(q_hit), 64'd0);
      chk("rst_ovf", 64'(ovf_err), 64'd0);
      #9 rst_n = 1'b1;

      // single mtspr
      step(1, 10'h100, 32'hDEADBEEF, 0, '0, 0, '0, 10'h100);
      idle(1);
      // three requests in one cycle
      step(1, 10'h100, 32'hAAAA0001, 1, 32'hBBBB0002, 1, 32'hCCCC0003, 10'd8);
      idle(2);
      // three consecutive full bursts: stall rises, nothing lost
      for (int i = 0; i < 3; i++)
         step(1, 10'(10'h110 + i), 32'h1000 + i, 1, 32'h2000 + i, 1, 32'h3000 + i, 10'd9);
      idle(6);
      // same-address pair on CTR
      step(1, 10'd9, 32'h0000_00A5, 1, 32'h0000_005A, 0, '0, 10'd9);
      idle(2);
      // CTR left pending in the FIFO, LR not pending
      step(1, 10'h101, 32'h11, 1, 32'h22, 1, 32'h33, 10'd9);
      step(1, 10'h102, 32'h44, 1, 32'h55, 0, '0, 10'd9);
      step(1, 10'h103, 32'h66, 1, 32'h77, 0, '0, 10'd9);
      qchk(10'd8);
      idle(3);

      // reset with two FIFO entries pending
      step(1, 10'h120, 32'h1, 1, 32'h2, 1, 32'h3, 10'd8);
      step(1, 10'h121, 32'h4, 1, 32'h5, 1, 32'h6, 10'd8);
      rst_n = 1'b0;
      q_addr = 10'd8;
      #1;
      chk("mid_rst_wr0", 64'(wr0), 64'd0);
      chk("mid_rst_wr1", 64'(wr1), 64'd0);
      chk("mid_rst_stall", 64'(stall), 64'd0);
      chk("mid_rst_q_hit", 64'(q_hit), 64'd0);
      pend.delete();
      iss.delete();
      m_ovf = 1'b0;
      #2 rst_n = 1'b1;
      idle(3);

      // random traffic respecting stall
      for (int i = 0; i < 300; i++) rnd_step(1);
      idle(4);
      // random traffic ignoring stall: drops and sticky error
      for (int i = 0; i < 100; i++) rnd_step(0);
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
